// File: rtl/spart_rx_if.sv
// Bus-side bundle of the SPART receiver: baud tick, serial pin, and the processor read interface.
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic                 rxd;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;
    logic                 parity_err;

    modport slave (
        input  enable,
        input  rxd,
        input  rd_ack,
        output rx_data,
        output rda,
        output framing_err,
        output overrun,
        output parity_err
    );

    modport master (
        output enable,
        output rxd,
        output rd_ack,
        input  rx_data,
        input  rda,
        input  framing_err,
        input  overrun,
        input  parity_err
    );
endinterface

// File: rtl/spart_rx.sv
// SPART serial receiver: oversampled 8N1 deserialiser raising rda with framing/overrun flags.
// Define SPART_RX_PARITY_EN for 8E1 frames (even parity bit before stop, parity_err flag).
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic      clk,
    input  logic      rst,
    spart_rx_if.slave bus
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef SPART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Nonzero when data plus received parity bit hold an odd number of ones.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic parity_bit);
        return (^data) ^ parity_bit;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_bit_q;
    logic                 armed_q;
    logic                 done_q;
`ifdef SPART_RX_PARITY_EN
    logic                 parity_bit_q;
`endif

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 pe_q, pe_d;

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rxd;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM with tick/bit counters and shift register; done_q pulses the clk after the stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= {TW{1'b0}};
            bit_q      <= {BW{1'b0}};
            shift_q    <= {DATA_BITS{1'b0}};
            stop_bit_q <= 1'b1;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tick_q <= {TW{1'b0}};
                    // armed_q blocks a held-low line (break) from starting repeated frames
                    if (rx_sync_q == 1'b1) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bus.enable) begin
                        if (tick_q == TICK_HALF) begin
                            tick_q <= {TW{1'b0}};
                            if (rx_sync_q == 1'b0) begin
                                state_q <= ST_DATA;
                                bit_q   <= {BW{1'b0}};
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.enable) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= {TW{1'b0}};
                            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`ifdef SPART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bus.enable) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q       <= {TW{1'b0}};
                            parity_bit_q <= rx_sync_q;
                            state_q      <= ST_STOP;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (bus.enable) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q     <= {TW{1'b0}};
                            stop_bit_q <= rx_sync_q;
                            done_q     <= 1'b1;
                            armed_q    <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tick_q  <= {TW{1'b0}};
                end
            endcase
        end
    end

    // Holding register update: a completing byte takes priority over a simultaneous read ack.
    always_comb begin
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
        ov_d      = ov_q;
        pe_d      = pe_q;
        if (done_q) begin
            rx_data_d = shift_q;
            rda_d     = 1'b1;
            fe_d      = ~stop_bit_q;
            ov_d      = rda_q & ~bus.rd_ack;
`ifdef SPART_RX_PARITY_EN
            pe_d      = parity_mismatch(shift_q, parity_bit_q);
`else
            pe_d      = 1'b0;
`endif
        end else if (bus.rd_ack) begin
            rda_d = 1'b0;
            fe_d  = 1'b0;
            ov_d  = 1'b0;
            pe_d  = 1'b0;
        end else begin
            rda_d = rda_q;
        end
    end

    // Processor-visible registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q <= {DATA_BITS{1'b0}};
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            pe_q      <= pe_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rda         = rda_q;
    assign bus.framing_err = fe_q;
    assign bus.overrun     = ov_q;
    assign bus.parity_err  = pe_q;

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: enable every 4 clks, 64-clk bit period, directed frames.
module tb_spart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_rx_if #(.DATA_BITS(8)) bus();

    spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef SPART_RX_PARITY_EN
    localparam int   NB     = 11;
    localparam logic PE_BAD = 1'b1;
`else
    localparam int   NB     = 10;
    localparam logic PE_BAD = 1'b0;
`endif
    // Stop bit is sampled at step 64*(NB-1)+31 of the frame; rda rises on the next posedge.
    localparam int DONE_STEP = 64 * (NB - 1) + 32;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ov;
        logic       pe;
        longint     t;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ecnt        = (ecnt + 1) % 4;
        bus.enable  = (ecnt == 0);
        bus.rd_ack  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.rxd = 1'b1;
        end
    endtask

    task automatic do_ack(input string name);
        tick();
        bus.rd_ack = 1'b1;
        tick();
        check({name, "_rda"}, bus.rda, 1'b0);
        check({name, "_fe"}, bus.framing_err, 1'b0);
        check({name, "_ov"}, bus.overrun, 1'b0);
        check({name, "_pe"}, bus.parity_err, 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp,
                        input bit ack_done, input int abort_step,
                        input logic efe, input logic eov, input logic epe);
        logic [NB-1:0] bits;
        exp_t          e;
        longint        t0;
`ifdef SPART_RX_PARITY_EN
        bits = {stp, par, d, 1'b0};
`else
        bits = {stp, d, 1'b0};
`endif
        while (ecnt != 0) begin
            tick();
            bus.rxd = 1'b1;
        end
        for (int s = 0; s < 64 * NB; s++) begin
            tick();
            if (s == 0) begin
                t0 = $time;
                if (abort_step < 0) begin
                    e.data = d;
                    e.fe   = efe;
                    e.ov   = eov;
                    e.pe   = epe;
                    e.t    = t0 + longint'(DONE_STEP) * 10 + 5;
                    sb_q.push_back(e);
                end
            end
            if (s == abort_step) begin
                rst = 1'b1;
                #1;
                check("abort_rda", bus.rda, 1'b0);
                check("abort_rx_data", bus.rx_data, 8'h00);
                check("abort_fe", bus.framing_err, 1'b0);
                check("abort_ov", bus.overrun, 1'b0);
                check("abort_pe", bus.parity_err, 1'b0);
                repeat (3) tick();
                rst     = 1'b0;
                bus.rxd = 1'b1;
                break;
            end
            bus.rxd = bits[s/64];
            if (ack_done && s == DONE_STEP) bus.rd_ack = 1'b1;
        end
    endtask

    // Monitor: a new byte shows as rda rising, or as new contents while rda stays high.
    initial begin
        logic        prev_rda;
        logic [10:0] prev_vec;
        logic [10:0] cur_vec;
        longint      te;
        exp_t        e;
        prev_rda = 1'b0;
        prev_vec = 11'd0;
        forever begin
            @(posedge clk);
            te = $time;
            #1;
            cur_vec = {bus.rx_data, bus.framing_err, bus.overrun, bus.parity_err};
            if (rst) begin
                prev_rda = 1'b0;
                prev_vec = 11'd0;
            end else begin
                if (bus.rda === 1'b1 && (prev_rda !== 1'b1 || cur_vec !== prev_vec)) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: actual %02h, expected no byte", bus.rx_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rx_data", bus.rx_data, e.data);
                        check("framing_err", bus.framing_err, e.fe);
                        check("overrun", bus.overrun, e.ov);
                        check("parity_err", bus.parity_err, e.pe);
                        check("rda_time", te, e.t);
                    end
                end
                prev_rda = bus.rda;
                prev_vec = cur_vec;
            end
        end
    end

    initial begin
        bus.rxd    = 1'b1;
        bus.enable = 1'b0;
        bus.rd_ack = 1'b0;
        repeat (3) tick();
        check("rst_rda", bus.rda, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_fe", bus.framing_err, 1'b0);
        check("rst_ov", bus.overrun, 1'b0);
        check("rst_pe", bus.parity_err, 1'b0);
        rst = 1'b0;
        idle(10);
        check("post_rst_rda", bus.rda, 1'b0);

        // 1: plain frame
        send(8'hA5, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        do_ack("ack_a5");

        // 2: short low glitch is rejected, then a good frame
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.rxd = 1'b0;
        end
        idle(60);
        check("glitch_rda", bus.rda, 1'b0);
        send(8'h3C, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        do_ack("ack_3c");

        // 3: stop bit low
        send(8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        idle(8);
        do_ack("ack_55");

        // 4: overrun, then the same pair with rd_ack on the completion clk
        send(8'h11, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        send(8'h22, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        idle(8);
        do_ack("ack_ovr");
        send(8'h11, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        send(8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        check("ack_at_done_rda", bus.rda, 1'b1);
        check("ack_at_done_ov", bus.overrun, 1'b0);

        // 5: reset during bit 4 of 0xF0, then a clean frame
        send(8'hF0, 1'b0, 1'b1, 1'b0, 330, 1'b0, 1'b0, 1'b0);
        idle(10);
        send(8'h0F, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        do_ack("ack_0f");

        // 6: 0x07 with good then bad parity bit (no parity flag in 8N1 build)
        send(8'h07, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle(8);
        do_ack("ack_07a");
        send(8'h07, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, PE_BAD);
        idle(8);
        do_ack("ack_07b");

        idle(20);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
